// File: rtl/filter_cfg_pkg.sv
// rtl/filter_cfg_pkg.sv - shared types, register map and field masks for the filter config bus
package filter_cfg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE        = 2'b00,
        OP_READ         = 2'b01,
        OP_WRITE_VERIFY = 2'b10,
        OP_RSVD         = 2'b11
    } cfg_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } cfg_state_e;

    localparam logic [3:0] ADDR_MAC_LO    = 4'd0;
    localparam logic [3:0] ADDR_MAC_HI    = 4'd1;
    localparam logic [3:0] ADDR_ETHERTYPE = 4'd2;
    localparam logic [3:0] ADDR_IP_PROTO  = 4'd3;
    localparam logic [3:0] ADDR_IP_SRC    = 4'd4;
    localparam logic [3:0] ADDR_IP_DST    = 4'd5;
    localparam logic [3:0] ADDR_UDP_PORT  = 4'd6;

    // Bits of each register that actually exist; verify ignores the rest
    function automatic logic [31:0] cfg_field_mask(input logic [3:0] addr);
        logic [31:0] m;
        m = 32'hFFFF_FFFF;
        case (addr)
            ADDR_MAC_LO, ADDR_IP_SRC, ADDR_IP_DST:    m = 32'hFFFF_FFFF;
            ADDR_MAC_HI, ADDR_ETHERTYPE, ADDR_UDP_PORT: m = 32'h0000_FFFF;
            ADDR_IP_PROTO:                            m = 32'h0000_00FF;
            default:                                  m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/filter_cfg_master.sv
// rtl/filter_cfg_master.sv - command-driven initiator for the filter register file
module filter_cfg_master
    import filter_cfg_pkg::*;
#(
    parameter int NUM_REGS  = 7,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [3:0]           cmd_addr,
    input  logic [31:0]          cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 cfg_we,
    output logic [3:0]           cfg_waddr,
    output logic [31:0]          cfg_wdata,
    output logic [3:0]           cfg_raddr,
    input  logic [31:0]          cfg_rdata,
    output logic [ERR_CNT_W-1:0] err_count
);

    cfg_state_e           r_state;
    cfg_op_e              r_op;
    logic [3:0]           r_addr;
    logic [31:0]          r_wdata;
    logic                 r_cmd_ready;
    logic                 r_rsp_valid;
    logic [31:0]          r_rsp_data;
    logic                 r_rsp_err;
    logic                 r_cfg_we;
    logic [3:0]           r_cfg_waddr;
    logic [31:0]          r_cfg_wdata;
    logic [3:0]           r_cfg_raddr;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic                 w_addr_bad;
    logic                 w_cmd_bad;
    logic                 w_verify_miss;

    assign w_addr_bad    = (32'(cmd_addr) >= 32'(NUM_REGS));
    assign w_cmd_bad     = w_addr_bad || (cmd_op == OP_RSVD);
    assign w_verify_miss = (((cfg_rdata ^ r_wdata) & cfg_field_mask(r_addr)) != 32'd0);

    // Command sequencer: one command in flight, all bus and response outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_WRITE;
            r_addr      <= 4'd0;
            r_wdata     <= 32'd0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_cfg_we    <= 1'b0;
            r_cfg_waddr <= 4'd0;
            r_cfg_wdata <= 32'd0;
            r_cfg_raddr <= 4'd0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cfg_op_e'(cmd_op);
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_cmd_ready <= 1'b0;
                        if (w_cmd_bad) begin
                            // No bus activity: answer with an error straight away
                            r_state     <= ST_RSP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= 32'd0;
                            r_rsp_err   <= 1'b1;
                        end else if (cmd_op == OP_READ) begin
                            r_state     <= ST_RD;
                            r_cfg_raddr <= cmd_addr;
                        end else begin
                            r_state     <= ST_WR;
                            r_cfg_we    <= 1'b1;
                            r_cfg_waddr <= cmd_addr;
                            r_cfg_wdata <= cmd_wdata;
                        end
                    end
                end
                ST_WR: begin
                    r_cfg_we <= 1'b0;
                    if (r_op == OP_WRITE_VERIFY) begin
                        // Read-back lands one cycle after the write edge, so it sees the new value
                        r_state     <= ST_RD;
                        r_cfg_raddr <= r_addr;
                    end else begin
                        r_state     <= ST_RSP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_wdata;
                        r_rsp_err   <= 1'b0;
                    end
                end
                ST_RD: begin
                    r_state     <= ST_RSP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= cfg_rdata;
                    r_rsp_err   <= (r_op == OP_WRITE_VERIFY) && w_verify_miss;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        if (r_rsp_err && (r_err_count != '1)) begin
                            r_err_count <= r_err_count + ERR_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_cfg_we    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign cfg_we    = r_cfg_we;
    assign cfg_waddr = r_cfg_waddr;
    assign cfg_wdata = r_cfg_wdata;
    assign cfg_raddr = r_cfg_raddr;
    assign err_count = r_err_count;

endmodule
